// File: rtl/seq_pkg.sv
// seq_pkg: shared types for the program sequencer and its return stack.
//   seq_state_t  - sequencer state (IDLE / RUN / FAULT)
//   seq_action_t - one decoded action per edge, from the strobe priority encoder
package seq_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} seq_state_t;
   typedef enum logic [2:0] {A_HOLD, A_INC, A_JMP, A_BRREL, A_CALL, A_RET} seq_action_t;
endpackage

// File: rtl/seq_ret_stack.sv
// seq_ret_stack: LIFO of return addresses.
//   clk, rst - clock, synchronous active-high reset (clears sp)
//   push     - write din to entry[sp], sp <= sp+1
//   pop      - sp <= sp-1; dout shows entry[sp-1] combinationally
//   din      - address to push
//   dout     - top-of-stack address
//   full     - sp == STACK_DEPTH
//   empty    - sp == 0
// The caller never asserts push and pop together and gates them with full/empty.
module seq_ret_stack #(
   parameter int AW          = 6,
   parameter int STACK_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] dout,
   output logic          full,
   output logic          empty
);
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   logic [SPW-1:0] sp;
   logic [SPW-1:0] sp_dec;
   logic [AW-1:0]  mem [2**IW];
   // sp < STACK_DEPTH whenever a push is allowed, so its low IW bits address the entry
   assign sp_dec = sp - 1'b1;
   assign dout   = mem[sp_dec[IW-1:0]];
   assign full   = sp == SPW'(STACK_DEPTH);
   assign empty  = sp == '0;
   always_ff @(posedge clk) begin
      if (rst) sp <= '0;
      else if (push) sp <= sp + 1'b1;
      else if (pop) sp <= sp_dec;
      if (push) mem[sp[IW-1:0]] <= din;
   end
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: program counter with start/arm handshake, relative branches
// and a call/return stack with sticky overflow/underflow fault.
//   clk, rst    - clock, synchronous active-high reset
//   start       - arms the sequencer while idle
//   complete    - level freeze of all state
//   inc         - pc <= pc+1
//   w_en        - pc <= data_in[AW-1:0]
//   br_rel      - pc <= pc + signed data_in[AW-1:0]
//   call        - push pc+1, pc <= data_in[AW-1:0]
//   ret         - pc <= popped address
//   data_in     - jump target / offset (low AW bits used)
//   pc          - current instruction address
//   running     - sequencer armed (stays high in FAULT)
//   stack_full  - stack holds STACK_DEPTH entries
//   stack_empty - stack holds no entries
//   fault       - sticky stack overflow/underflow
module program_sequencer
   import seq_pkg::*;
#(
   parameter int AW          = 6,
   parameter int DW          = 32,
   parameter int RESET_ADDR  = 2,
   parameter int STACK_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          complete,
   input  logic          inc,
   input  logic          w_en,
   input  logic          br_rel,
   input  logic          call,
   input  logic          ret,
   input  logic [DW-1:0] data_in,
   output logic [AW-1:0] pc,
   output logic          running,
   output logic          stack_full,
   output logic          stack_empty,
   output logic          fault
);
   seq_state_t    state;
   seq_action_t   act;
   logic [AW-1:0] tgt;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] top;
   logic          live;
   logic          push;
   logic          pop;
   logic          unused_hi;
   assign tgt       = data_in[AW-1:0];
   assign unused_hi = ^data_in;
   assign pc_inc    = pc + AW'(1);
   assign live      = state == S_RUN && !complete;
   always_comb begin
      act = ret    ? A_RET   :
            call   ? A_CALL  :
            w_en   ? A_JMP   :
            br_rel ? A_BRREL :
            inc    ? A_INC   : A_HOLD;
   end
   assign push = live && act == A_CALL && !stack_full;
   assign pop  = live && act == A_RET && !stack_empty;
   seq_ret_stack #(.AW(AW), .STACK_DEPTH(STACK_DEPTH)) u_stack (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .din  (pc_inc),
      .dout (top),
      .full (stack_full),
      .empty(stack_empty)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         pc      <= AW'(RESET_ADDR);
         running <= 1'b0;
         fault   <= 1'b0;
      end else if (!complete) begin
         case (state)
            S_IDLE: if (start) begin
               state   <= S_RUN;
               running <= 1'b1;
            end
            S_RUN: case (act)
               A_RET: if (stack_empty) begin
                  state <= S_FAULT;
                  fault <= 1'b1;
               end else pc <= top;
               A_CALL: if (stack_full) begin
                  state <= S_FAULT;
                  fault <= 1'b1;
               end else pc <= tgt;
               A_JMP:   pc <= tgt;
               A_BRREL: pc <= pc + tgt;
               A_INC:   pc <= pc_inc;
               default: pc <= pc;
            endcase
            default: state <= state;
         endcase
      end
   end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed and randomized checks against a queue-based model.
module tb_program_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b0, start = 1'b0, complete = 1'b0, inc = 1'b0;
   logic        w_en = 1'b0, br_rel = 1'b0, call = 1'b0, ret = 1'b0;
   logic [31:0] data_in = '0;
   logic [5:0]  pc;
   logic        running, stack_full, stack_empty, fault;
   int          checks = 0;
   int          errors = 0;
   int          m_pc = 2;
   bit          m_run = 0;
   bit          m_fault = 0;
   int          m_stk[$];

   program_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .complete(complete), .inc(inc),
      .w_en(w_en), .br_rel(br_rel), .call(call), .ret(ret), .data_in(data_in),
      .pc(pc), .running(running), .stack_full(stack_full),
      .stack_empty(stack_empty), .fault(fault)
   );

   always #5 clk = ~clk;

   // Reference: one prioritized action per edge, stack as a queue, addresses mod 64.
   task automatic model_edge(input bit r, s, cp, i, w, b, c, rt, input logic [31:0] d);
      int t;
      t = int'(d & 32'h3F);
      if (r) begin
         m_pc = 2; m_run = 0; m_fault = 0; m_stk.delete();
      end else if (cp || m_fault) begin
      end else if (!m_run) begin
         if (s) m_run = 1;
      end else if (rt) begin
         if (m_stk.size() == 0) m_fault = 1;
         else m_pc = m_stk.pop_back();
      end else if (c) begin
         if (m_stk.size() == 4) m_fault = 1;
         else begin
            m_stk.push_back((m_pc + 1) % 64);
            m_pc = t;
         end
      end else if (w) m_pc = t;
      else if (b) m_pc = (m_pc + t) % 64;
      else if (i) m_pc = (m_pc + 1) % 64;
   endtask

   task automatic apply(input bit r, s, cp, i, w, b, c, rt, input logic [31:0] d);
      rst = r; start = s; complete = cp; inc = i; w_en = w; br_rel = b;
      call = c; ret = rt; data_in = d;
      @(posedge clk);
      #1;
      model_edge(r, s, cp, i, w, b, c, rt, d);
   endtask

   task automatic idle_rst_start();
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (pc !== 6'd2) begin errors++; $display("FAIL reset_pc: got %0d expected 2", pc); end
      checks++; if ({running, fault, stack_empty, stack_full} !== 4'b0010) begin
         errors++; $display("FAIL reset_flags: got run=%b flt=%b emp=%b full=%b expected 0 0 1 0", running, fault, stack_empty, stack_full);
      end
      repeat (3) apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
      checks++; if (pc !== 6'd2 || running !== 1'b0) begin errors++; $display("FAIL idle_inc: got pc=%0d run=%b expected pc=2 run=0", pc, running); end
      apply(0, 1, 0, 1, 1, 0, 0, 0, 32'd40);
      checks++; if (pc !== 6'd2 || running !== 1'b1) begin errors++; $display("FAIL arm: got pc=%0d run=%b expected pc=2 run=1", pc, running); end
      repeat (3) apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
      checks++; if (pc !== 6'd5) begin errors++; $display("FAIL run_inc: got %0d expected 5", pc); end
   endtask

   task automatic test_wrap_branch();
      apply(0, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FF3F);
      apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
      checks++; if (pc !== 6'd0) begin errors++; $display("FAIL inc_wrap: got %0d expected 0", pc); end
      apply(0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_003E);
      checks++; if (pc !== 6'd62) begin errors++; $display("FAIL br_back: got %0d expected 62", pc); end
      apply(0, 0, 0, 0, 0, 1, 0, 0, 32'd5);
      checks++; if (pc !== 6'd3) begin errors++; $display("FAIL br_fwd_wrap: got %0d expected 3", pc); end
   endtask

   task automatic test_call_ret();
      apply(0, 0, 0, 0, 1, 0, 0, 0, 32'd10);
      apply(0, 0, 0, 0, 0, 0, 1, 0, 32'd20);
      apply(0, 0, 0, 0, 0, 0, 1, 0, 32'd30);
      checks++; if (pc !== 6'd30 || stack_empty !== 1'b0 || stack_full !== 1'b0) begin
         errors++; $display("FAIL nest_call: got pc=%0d emp=%b full=%b expected pc=30 emp=0 full=0", pc, stack_empty, stack_full);
      end
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (pc !== 6'd21) begin errors++; $display("FAIL ret1: got %0d expected 21", pc); end
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (pc !== 6'd11 || stack_empty !== 1'b1) begin errors++; $display("FAIL ret2: got pc=%0d emp=%b expected pc=11 emp=1", pc, stack_empty); end
      apply(0, 0, 0, 0, 0, 0, 1, 0, 32'd40);
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (pc !== 6'd12 || stack_empty !== 1'b1) begin errors++; $display("FAIL call_ret_b2b: got pc=%0d emp=%b expected pc=12 emp=1", pc, stack_empty); end
      apply(0, 0, 0, 0, 1, 0, 0, 0, 32'd63);
      apply(0, 0, 0, 0, 0, 0, 1, 0, 32'd7);
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (pc !== 6'd0) begin errors++; $display("FAIL ret_addr_wrap: got %0d expected 0", pc); end
   endtask

   task automatic test_overflow();
      idle_rst_start();
      for (int i = 1; i <= 4; i++) apply(0, 0, 0, 0, 0, 0, 1, 0, 32'(i * 5));
      checks++; if (stack_full !== 1'b1 || fault !== 1'b0 || pc !== 6'd20) begin
         errors++; $display("FAIL four_calls: got full=%b flt=%b pc=%0d expected 1 0 20", stack_full, fault, pc);
      end
      apply(0, 0, 0, 0, 0, 0, 1, 0, 32'd33);
      checks++; if (fault !== 1'b1 || pc !== 6'd20 || running !== 1'b1) begin
         errors++; $display("FAIL overflow: got flt=%b pc=%0d run=%b expected 1 20 1", fault, pc, running);
      end
      apply(0, 0, 0, 1, 1, 0, 0, 1, 32'd9);
      checks++; if (pc !== 6'd20 || stack_full !== 1'b1 || fault !== 1'b1) begin
         errors++; $display("FAIL fault_hold: got pc=%0d full=%b flt=%b expected 20 1 1", pc, stack_full, fault);
      end
      idle_rst_start();
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (fault !== 1'b1 || pc !== 6'd2) begin errors++; $display("FAIL underflow: got flt=%b pc=%0d expected 1 2", fault, pc); end
   endtask

   task automatic test_priority();
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 1, 1, 0, 0, 0, 0, 0, 0);
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL complete_blocks_arm: got run=%b expected 0", running); end
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 1, 0, 0, 0, 32'd7);
      repeat (2) apply(0, 0, 1, 0, 1, 0, 0, 0, 32'd40);
      checks++; if (pc !== 6'd7) begin errors++; $display("FAIL complete_freeze: got %0d expected 7", pc); end
      apply(0, 0, 0, 0, 1, 1, 0, 0, 32'd44);
      checks++; if (pc !== 6'd44) begin errors++; $display("FAIL jmp_over_br: got %0d expected 44", pc); end
      apply(0, 0, 0, 0, 0, 0, 1, 0, 32'd20);
      apply(0, 0, 0, 1, 1, 0, 1, 1, 32'd50);
      checks++; if (pc !== 6'd45 || stack_empty !== 1'b1) begin errors++; $display("FAIL ret_wins: got pc=%0d emp=%b expected 45 1", pc, stack_empty); end
   endtask

   task automatic test_reset_midrun();
      idle_rst_start();
      for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 0, 0, 1, 0, 32'(i + 11));
      apply(1, 0, 1, 1, 0, 0, 0, 0, 0);
      checks++; if ({pc, running, fault, stack_empty, stack_full} !== {6'd2, 4'b0010}) begin
         errors++; $display("FAIL rst_in_fault: got pc=%0d run=%b flt=%b emp=%b full=%b expected 2 0 0 1 0", pc, running, fault, stack_empty, stack_full);
      end
   endtask

   task automatic test_random();
      idle_rst_start();
      for (int n = 0; n < 400; n++) begin
         apply($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
               $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15, $urandom);
         checks++;
         if (pc !== 6'(m_pc) || running !== m_run || fault !== m_fault ||
             stack_empty !== (m_stk.size() == 0) || stack_full !== (m_stk.size() == 4)) begin
            errors++;
            $display("FAIL random[%0d]: got pc=%0d run=%b flt=%b emp=%b full=%b expected pc=%0d run=%b flt=%b sp=%0d",
                     n, pc, running, fault, stack_empty, stack_full, m_pc, m_run, m_fault, m_stk.size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_wrap_branch();
      test_call_ret();
      test_overflow();
      test_priority();
      test_reset_midrun();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
